// File: rtl/wishbone_nslave_interconnect.sv
// One-master / NUM_SLAVES-slave Wishbone interconnect with latched slave decode and error termination.
// Optional stall timeout on unresponsive slaves is built when WB_IC_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no cycle in flight, slave ports quiet, waiting for cyc&stb
// ACTIVE   | mapped slave selected by latched idx, strobes/acks routed
// ERR      | single-cycle error termination to the master
// WAIT_END | error delivered, hold slaves quiet until master drops cyc

module wishbone_nslave_interconnect #(
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_MSB        = 31,
    parameter int SEL_LSB        = 24,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_we_i,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic [31:0]              m_adr_i,
    input  logic [31:0]              m_dat_i,
    output logic [31:0]              m_dat_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic                     m_int_o,
    output logic [NUM_SLAVES-1:0]    s_we_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic [31:0]              s_adr_o,
    output logic [31:0]              s_dat_o,
    input  logic [32*NUM_SLAVES-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i,
    input  logic [NUM_SLAVES-1:0]    s_int_i,
    output logic [31:0]              err_adr_o,
    output logic [7:0]               err_cnt_o
);

    localparam int IDX_W = SEL_MSB - SEL_LSB + 1;
    localparam int SLV_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        ERR      = 2'd2,
        WAIT_END = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   adr_idx;
    logic [31:0]        adr_idx_ext;
    logic               in_range;
    logic               start;
    logic [SLV_W-1:0]   idx_q;
    logic [31:0]        sel_dat;
    logic               sel_ack;
    logic               timeout_hit;
    logic [31:0]        err_adr_q;
    logic [7:0]         err_cnt_q;

    assign adr_idx     = m_adr_i[SEL_MSB:SEL_LSB];
    assign adr_idx_ext = 32'(adr_idx);
    assign in_range    = adr_idx_ext < 32'(NUM_SLAVES);
    assign start       = m_cyc_i && m_stb_i;

    assign s_adr_o   = {{(32-SEL_LSB){1'b0}}, m_adr_i[SEL_LSB-1:0]};
    assign s_dat_o   = m_dat_i;
    assign m_int_o   = |s_int_i;
    assign err_adr_o = err_adr_q;
    assign err_cnt_o = err_cnt_q;

    // Return path mux through the latched index; unselected slaves never reach the master.
    always_comb begin
        sel_dat = '0;
        sel_ack = 1'b0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == SLV_W'(k)) begin
                sel_dat = s_dat_i[32*k +: 32];
                sel_ack = s_ack_i[k];
            end
        end
    end

`ifdef WB_IC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;

    assign timeout_hit = (tmo_cnt_q >= TMO_W'(TIMEOUT_CYCLES)) && !sel_ack;

    always_ff @(posedge clk) begin
        if (rst || state_q != ACTIVE) begin
            tmo_cnt_q <= '0;
        end else if (sel_ack) begin
            tmo_cnt_q <= '0;
        end else if (m_stb_i && !timeout_hit) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = in_range ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = WAIT_END;
            end
            WAIT_END: begin
                if (!m_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        s_we_o  = '0;
        m_ack_o = 1'b0;
        m_err_o = 1'b0;
        m_dat_o = '0;
        case (state_q)
            ACTIVE: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (idx_q == SLV_W'(k) && !timeout_hit) begin
                        s_cyc_o[k] = m_cyc_i;
                        s_stb_o[k] = m_stb_i;
                        s_we_o[k]  = m_we_i;
                    end
                end
                m_ack_o = sel_ack;
                m_dat_o = sel_dat;
            end
            ERR: begin
                m_err_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Index is captured only at cycle start so address changes mid-cycle cannot reroute.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (state_q == IDLE && start) begin
            idx_q <= adr_idx[SLV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_adr_q <= '0;
            err_cnt_q <= '0;
        end else if (state_d == ERR && state_q != ERR) begin
            err_adr_q <= m_adr_i;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wishbone_nslave_interconnect.sv
// Self-checking bench for wishbone_nslave_interconnect: transaction-level model plus directed accesses.
// Timeout scenario is exercised only when WB_IC_TIMEOUT_EN is defined.

module tb_wishbone_nslave_interconnect;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_we, m_cyc, m_stb;
    logic [31:0]  m_adr, m_dat;
    logic [31:0]  m_dat_o;
    logic         m_ack_o, m_err_o, m_int_o;
    logic [3:0]   s_we_o, s_cyc_o, s_stb_o;
    logic [31:0]  s_adr_o, s_dat_o;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i, s_int_i;
    logic [31:0]  err_adr_o;
    logic [7:0]   err_cnt_o;

    logic [3:0]   slv_ack;
    logic [3:0]   ack_en;
    logic [3:0]   xtra_ack;
    logic [31:0]  slv_dat [4];
    logic [31:0]  gpio_out;

    int errs   = 0;
    int checks = 0;
    logic chk_on = 1'b0;

`ifdef WB_IC_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    wishbone_nslave_interconnect dut (
        .clk       (clk),
        .rst       (rst),
        .m_we_i    (m_we),
        .m_cyc_i   (m_cyc),
        .m_stb_i   (m_stb),
        .m_adr_i   (m_adr),
        .m_dat_i   (m_dat),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .m_int_o   (m_int_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_dat_i   (s_dat_i),
        .s_ack_i   (s_ack_i),
        .s_int_i   (s_int_i),
        .err_adr_o (err_adr_o),
        .err_cnt_o (err_cnt_o)
    );

    // Slaves: registered ack one cycle after seeing stb; slave 1 doubles as a gpio register.
    assign s_dat_i = {slv_dat[3], slv_dat[2], slv_dat[1], slv_dat[0]};
    assign s_ack_i = slv_ack | xtra_ack;

    always @(posedge clk) begin
        if (rst) slv_ack <= 4'b0;
        else     slv_ack <= ack_en & s_stb_o & ~slv_ack;
    end

    always @(posedge clk) begin
        if (rst)                                       gpio_out <= 32'hDEAD_BEEF;
        else if (s_stb_o[1] && s_we_o[1] && !slv_ack[1]) gpio_out <= s_dat_o;
    end

    // Transaction model: one outstanding master cycle, target chosen from the top address byte.
    logic        mb_busy, mb_mapped, mb_err_now;
    logic [1:0]  mb_tgt;
    int          mb_stall, mb_ecnt;
    logic [31:0] mb_eadr;
    logic        tgt_ack, tmo_fire, live;
    logic [3:0]  exp_oh;

    assign tgt_ack  = s_ack_i[mb_tgt];
    assign tmo_fire = TMO_ON && mb_busy && mb_mapped && (mb_stall >= 16) && !tgt_ack;
    assign live     = mb_busy && mb_mapped && !tmo_fire;
    assign exp_oh   = live ? (4'b0001 << mb_tgt) : 4'b0000;

    always @(posedge clk) begin
        if (rst) begin
            mb_busy <= 1'b0; mb_mapped <= 1'b0; mb_err_now <= 1'b0; mb_tgt <= 2'd0;
            mb_stall <= 0; mb_ecnt <= 0; mb_eadr <= 32'h0;
        end else if (!mb_busy) begin
            if (m_cyc && m_stb) begin
                mb_busy   <= 1'b1;
                mb_tgt    <= m_adr[25:24];
                mb_mapped <= (m_adr[31:24] < 8'd4);
                mb_stall  <= 0;
                if (m_adr[31:24] >= 8'd4) begin
                    mb_err_now <= 1'b1;
                    mb_ecnt    <= (mb_ecnt == 255) ? 255 : mb_ecnt + 1;
                    mb_eadr    <= m_adr;
                end
            end
        end else if (mb_err_now) begin
            mb_err_now <= 1'b0;
        end else if (!m_cyc) begin
            mb_busy   <= 1'b0;
            mb_mapped <= 1'b0;
        end else if (mb_mapped) begin
            if (tmo_fire) begin
                mb_mapped  <= 1'b0;
                mb_err_now <= 1'b1;
                mb_ecnt    <= (mb_ecnt == 255) ? 255 : mb_ecnt + 1;
                mb_eadr    <= m_adr;
            end else if (tgt_ack) begin
                mb_stall <= 0;
            end else if (m_stb) begin
                mb_stall <= mb_stall + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            check("s_stb_o", 32'(s_stb_o), 32'(exp_oh & {4{m_stb}}));
            check("s_cyc_o", 32'(s_cyc_o), 32'(exp_oh & {4{m_cyc}}));
            check("s_we_o",  32'(s_we_o),  32'(exp_oh & {4{m_we}}));
            check("m_ack_o", 32'(m_ack_o), 32'(mb_busy && mb_mapped && tgt_ack));
            check("m_err_o", 32'(m_err_o), 32'(mb_busy && mb_err_now));
            check("m_dat_o", m_dat_o, (mb_busy && mb_mapped) ? slv_dat[mb_tgt] : 32'h0);
            check("err_cnt_o", 32'(err_cnt_o), 32'(mb_ecnt));
            check("err_adr_o", err_adr_o, mb_eadr);
            check("s_adr_o", s_adr_o, {8'h00, m_adr[23:0]});
            check("s_dat_o", s_dat_o, m_dat);
            check("m_int_o", 32'(m_int_o), 32'(|s_int_i));
            check("ack_err_excl", 32'(m_ack_o && m_err_o), 32'h0);
        end
    end

    task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                             output int lat, output logic got_ack, output logic got_err,
                             output logic [31:0] rd, output logic [3:0] stb_or, output logic [31:0] sadr);
        @(negedge clk);
        m_adr = adr; m_we = we; m_dat = wd; m_cyc = 1'b1; m_stb = 1'b1;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; rd = 32'h0; stb_or = 4'b0; sadr = 32'h0;
        while (!got_ack && !got_err && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            stb_or  = stb_or | s_stb_o;
            got_ack = m_ack_o;
            got_err = m_err_o;
            rd      = m_dat_o;
            sadr    = s_adr_o;
        end
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(negedge clk);
        if (!got_ack && !got_err) begin
            errs++; checks++;
            $display("FAIL access_timeout: adr %h got no ack or err within 64 cycles", adr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        logic ga, ge;
        logic [31:0] rd, sadr;
        logic [3:0] so;

        rst = 1'b1; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_adr = 32'h0; m_dat = 32'h0;
        s_int_i = 4'b0; xtra_ack = 4'b0; ack_en = 4'b1011;
        slv_dat[0] = 32'h1234_5678; slv_dat[1] = 32'h1111_0001;
        slv_dat[2] = 32'h2222_0002; slv_dat[3] = 32'h3333_0003;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        @(posedge clk); #1;
        check("rst_ack", 32'(m_ack_o), 32'h0);
        check("rst_err", 32'(m_err_o), 32'h0);
        check("rst_stb", 32'(s_stb_o), 32'h0);
        check("rst_err_cnt", 32'(err_cnt_o), 32'h0);

        // Write zero to gpio on slave 1
        wb_access(32'h0100_0000, 1'b1, 32'h0, lat, ga, ge, rd, so, sadr);
        check("wr_stb_mask", 32'(so), 32'h2);
        check("wr_sadr", sadr, 32'h0);
        check("wr_ack", 32'(ga), 32'h1);
        check("wr_lat", 32'(lat), 32'd2);
        check("wr_gpio", gpio_out, 32'h0);

        // Read slave 0 with a stray ack on slave 3 that must be ignored
        xtra_ack = 4'b1000;
        wb_access(32'h0000_0004, 1'b0, 32'h0, lat, ga, ge, rd, so, sadr);
        xtra_ack = 4'b0000;
        check("rd_ack", 32'(ga), 32'h1);
        check("rd_dat", rd, 32'h1234_5678);
        check("rd_lat", 32'(lat), 32'd2);
        check("rd_sadr", sadr, 32'h4);

        // Unmapped slave 5, stray ack on slave 0 must not produce an ack
        xtra_ack = 4'b0001;
        wb_access(32'h0500_0010, 1'b0, 32'h0, lat, ga, ge, rd, so, sadr);
        xtra_ack = 4'b0000;
        check("um_err", 32'(ge), 32'h1);
        check("um_ack", 32'(ga), 32'h0);
        check("um_lat", 32'(lat), 32'd1);
        check("um_stb", 32'(so), 32'h0);
        check("um_err_adr", err_adr_o, 32'h0500_0010);
        check("um_err_cnt", 32'(err_cnt_o), 32'h1);

        // Address field change mid-cycle must not reroute
        ack_en[0] = 1'b0;
        @(negedge clk);
        m_adr = 32'h0000_0020; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0;
        repeat (2) @(negedge clk);
        m_adr = 32'h0300_0000;
        @(negedge clk); #1;
        check("hold_stb", 32'(s_stb_o), 32'h1);
        ack_en[0] = 1'b1;
        n = 0;
        while (!m_ack_o && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_ack", 32'(m_ack_o), 32'h1);
        check("hold_dat", m_dat_o, 32'h1234_5678);
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            wb_access(32'hFF00_0000 | 32'(i), 1'b0, 32'h0, lat, ga, ge, rd, so, sadr);
        end
        check("sat_err_cnt", 32'(err_cnt_o), 32'd255);
        check("sat_err_adr", err_adr_o, 32'hFF00_0103);

        // Reset in the middle of an access to slave 3
        ack_en[3] = 1'b0;
        @(negedge clk);
        m_adr = 32'h0300_0008; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_dat = 32'hA5A5_5A5A;
        @(posedge clk); #1;
        check("pre_rst_stb", 32'(s_stb_o), 32'h8);
        @(negedge clk);
        rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        @(posedge clk); #1;
        check("post_rst_stb", 32'(s_stb_o), 32'h0);
        check("post_rst_cyc", 32'(s_cyc_o), 32'h0);
        check("post_rst_we", 32'(s_we_o), 32'h0);
        check("post_rst_err_cnt", 32'(err_cnt_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_en[3] = 1'b1;

        // Interrupt OR is combinational
        s_int_i = 4'b1000; #1;
        check("int_hi", 32'(m_int_o), 32'h1);
        s_int_i = 4'b0000; #1;
        check("int_lo", 32'(m_int_o), 32'h0);

`ifdef WB_IC_TIMEOUT_EN
        wb_access(32'h0200_0000, 1'b0, 32'h0, lat, ga, ge, rd, so, sadr);
        check("tmo_err", 32'(ge), 32'h1);
        check("tmo_lat", 32'(lat), 32'd18);
        check("tmo_err_cnt", 32'(err_cnt_o), 32'h1);
        wb_access(32'h0000_0000, 1'b0, 32'h0, lat, ga, ge, rd, so, sadr);
        check("tmo_next_ack", 32'(ga), 32'h1);
        check("tmo_next_dat", rd, 32'h1234_5678);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/wishbone_nslave_interconnect.md
# wishbone_nslave_interconnect

Parametrised Wishbone interconnect between one `wishbone_master` and NUM_SLAVES slaves (device ROM table at index 0, peripherals above). It decodes the slave index from the upper address bits and latches it for the whole bus cycle. It routes strobes, acks, data and interrupts, and terminates cycles to unmapped or unresponsive slaves with a one-cycle error pulse, so the master can never hang.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..256)
- SEL_MSB, 31, MSB of the slave-index field in m_adr_i
- SEL_LSB, 24, LSB of the slave-index field; bits [SEL_LSB-1:0] form the slave-local address
- TIMEOUT_CYCLES, 16, cycles of stb without ack before forced error (requires WB_IC_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- m_we_i / m_cyc_i / m_stb_i  in  1 each  master control
- m_adr_i  in  32  master address
- m_dat_i  in  32  master write data
- m_dat_o  out  32  read data to master
- m_ack_o  out  1  ack to master
- m_err_o  out  1  error termination to master
- m_int_o  out  1  OR of all slave interrupts
- s_we_o / s_cyc_o / s_stb_o  out  NUM_SLAVES each  per-slave control; only the selected bit is ever set
- s_adr_o  out  32  slave-local address: {zeros, m_adr_i[SEL_LSB-1:0]}
- s_dat_o  out  32  broadcast write data (= m_dat_i)
- s_dat_i  in  32*NUM_SLAVES  slave read data; slave k uses bits [32k+31:32k]
- s_ack_i  in  NUM_SLAVES  slave acks
- s_int_i  in  NUM_SLAVES  slave interrupts
- err_adr_o  out  32  m_adr_i captured at the last error
- err_cnt_o  out  8  saturating error count

## Operation
- FSM states: IDLE, ACTIVE, ERR, WAIT_END.
- IDLE: all s_*_o low. When m_cyc_i&m_stb_i: latch idx = m_adr_i[SEL_MSB:SEL_LSB]. If idx < NUM_SLAVES, go to ACTIVE. Otherwise go to ERR.
- ACTIVE:
  - s_cyc_o[idx]=m_cyc_i, s_stb_o[idx]=m_stb_i, s_we_o[idx]=m_we_i.
  - m_ack_o=s_ack_i[idx], m_dat_o=s_dat_i[idx] (combinational through the latched idx).
  - m_cyc_i low → IDLE.
  - idx is held for the whole cycle; address-field changes during cyc are ignored.
- ERR: one cycle with m_err_o=1, m_ack_o=0, m_dat_o=0. err_adr_o is captured and err_cnt_o increments, saturating at 255. Next state is WAIT_END.
- WAIT_END: all slave outputs low. Leave for IDLE when m_cyc_i is low.
- Interrupts: m_int_o = |s_int_i, combinational, independent of FSM state.
- Reset: state IDLE. m_ack_o, m_err_o, m_dat_o, all s_*_o, err_adr_o, err_cnt_o and timeout counter all reset to 0. A reset mid-cycle drops the slave strobes in the next cycle.

## Timing
- Decode adds one cycle. The slave sees stb 1 cycle after the master asserts it.
- Ack and data paths back to the master are zero-latency from the slave.
- Unmapped access: m_err_o is high in the 2nd cycle after master stb. It is never accompanied by ack.
- m_ack_o and m_err_o are mutually exclusive in every cycle.
- m_cyc_i dropping while the FSM is in ERR: ERR still completes its one cycle, then WAIT_END exits on the next cycle.
- s_ack_i from a non-selected slave is ignored.

## Configuration
- WB_IC_TIMEOUT_EN defined:
  - In ACTIVE, a counter increments each cycle that m_stb_i=1 and s_ack_i[idx]=0. It clears on ack and on entry to ACTIVE.
  - When it reaches TIMEOUT_CYCLES: deassert s_cyc_o/s_stb_o and go to ERR.
  - Error pulse appears TIMEOUT_CYCLES+1 cycles after the slave stb.
- WB_IC_TIMEOUT_EN undefined:
  - No counter; ACTIVE waits indefinitely for ack.
  - ERR is reachable only via unmapped idx.

## Test plan
- Write 0x0000_0000 to slave 1 at m_adr_i=0x0100_0000 (simple_gpio, ack next cycle) → s_stb_o=4'b0010, s_adr_o=0, m_ack_o one cycle, gpio_out=0; no other s_stb_o bit set.
- Read m_adr_i=0x0000_0004 with slave 0 returning 0x1234_5678 → m_dat_o=0x1234_5678 with m_ack_o, and cycle count from master stb to ack = 2.
- Access m_adr_i=0x0500_0010 with NUM_SLAVES=4 → m_err_o pulse, m_ack_o=0, err_adr_o=0x0500_0010, err_cnt_o=1, no s_stb_o activity.
- With WB_IC_TIMEOUT_EN defined, slave 2 never acks → s_stb_o[2] drops and m_err_o pulses 17 cycles after slave stb (TIMEOUT_CYCLES=16). The FSM returns to IDLE after m_cyc_i drops, and the next access to slave 0 succeeds.
- Assert rst during ACTIVE on slave 3 → all s_*_o=0 and err_cnt_o=0 next cycle. Set s_int_i=4'b1000 → m_int_o=1 in the same cycle.
